// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive slice: receiver FSM encodings,
// data width, default baud divisor and the even-parity helper.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int DEFAULT_BAUD_DIV = 217;

  // Encodings are fixed so the parity state keeps its code whether or not
  // the parity feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Even parity: the transmitted parity bit equals the XOR of the data bits.
  function automatic logic even_parity(input logic [UART_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous first-word-fall-through FIFO (DEPTH a power of two >= 2).
// The head word is presented on rdata_o while non-empty and reads as zero
// when empty. A push into a full FIFO is accepted only together with a pop.
module uart_rx_fifo_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign count_o   = count_q;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Head word, forced to zero when nothing is queued.
  always_comb begin
    if (empty_o) begin
      rdata_o = {WIDTH{1'b0}};
    end else begin
      rdata_o = mem_q[rd_ptr_q];
    end
  end

  // Next pointer and occupancy values; pointers wrap naturally mod DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, the empty mux hides them.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, LSB first, one stop bit) feeding a receive FIFO.
// rxd is synchronised by two flops; each bit is sampled at its midpoint.
// Optional feature: define UART_RX_PARITY_EN to expect an even parity bit
// after D7; a parity mismatch sets parity_err and drops the byte.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  input  logic                          rd,
  input  logic                          err_clr,
  output logic [UART_DATA_W-1:0]        rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV - 1);

  logic                   sync1_q, rxs_q;
  rx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   par_bad_q;
  logic                   frame_err_q, overrun_q;
  logic                   tick_s, push_s, stop_bad_s, pop_s;
  logic                   fifo_full_s, fifo_empty_s;

  // Two-flop synchroniser for the asynchronous serial input (idles high).
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  // Mid-stop-bit decision: push a good byte or flag a framing error.
  always_comb begin
    tick_s     = (cnt_q == CNT_ZERO);
    push_s     = 1'b0;
    stop_bad_s = 1'b0;
    if (tick_s && (state_q == ST_STOP)) begin
      if (rxs_q) begin
        push_s     = ~par_bad_q;
        stop_bad_s = 1'b0;
      end else begin
        push_s     = 1'b0;
        stop_bad_s = 1'b1;
      end
    end else begin
      push_s     = 1'b0;
      stop_bad_s = 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_set_s;
  assign par_err_set_s = tick_s && (state_q == ST_PARITY) &&
                         (rxs_q != even_parity(shift_q));
  logic parity_err_q;

  // Sticky parity error; a new mismatch wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else if (par_err_set_s) begin
      parity_err_q <= 1'b1;
    end else if (err_clr) begin
      parity_err_q <= 1'b0;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  // Receiver FSM with its baud counter, bit index and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      bit_q     <= 3'd0;
      shift_q   <= {UART_DATA_W{1'b0}};
      par_bad_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rxs_q) begin
            state_q <= ST_START;
            cnt_q   <= CNT_HALF;
          end
        end
        ST_START: begin
          if (tick_s) begin
            if (!rxs_q) begin
              state_q   <= ST_DATA;
              cnt_q     <= CNT_FULL;
              bit_q     <= 3'd0;
              par_bad_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;  // start bit did not hold: treat as a glitch
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (tick_s) begin
            shift_q <= {rxs_q, shift_q[UART_DATA_W-1:1]};
            cnt_q   <= CNT_FULL;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick_s) begin
            par_bad_q <= par_err_set_s;
            cnt_q     <= CNT_FULL;
            state_q   <= ST_STOP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (tick_s) begin
            // Leave at mid stop bit so a back-to-back start edge is seen.
            state_q <= rxs_q ? ST_IDLE : ST_WAIT_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          if (rxs_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky frame and overrun flags; setting wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (stop_bad_s) begin
        frame_err_q <= 1'b1;
      end else if (err_clr) begin
        frame_err_q <= 1'b0;
      end
      if (push_s && fifo_full_s && !pop_s) begin
        overrun_q <= 1'b1;
      end else if (err_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign pop_s     = rd & ~fifo_empty_s;
  assign rx_valid  = ~fifo_empty_s;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  uart_rx_fifo_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .wdata_i (shift_q),
    .pop_i   (pop_s),
    .rdata_o (rx_data),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (rx_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: drives serial frames bit by bit and
// compares the FIFO interface against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int BAUD_DIV   = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, rxd, rd, err_clr;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] rx_count;
  logic          frame_err, parity_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected FIFO contents and sticky flags.
  logic [7:0] model_q[$];
  logic       m_frame, m_par, m_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rd(rd), .err_clr(err_clr),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_count(rx_count),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    tick(BAUD_DIV);
  endtask

  // Start bit and eight data bits (LSB first), plus parity when built in.
  task automatic send_head(input logic [7:0] b, input logic par_ok);
    logic pb;
    pb = par_ok ? ^b : ~^b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pb);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
    send_head(b, par_ok);
    drive_bit(stop_v);
    rxd = 1'b1;
  endtask

  // Model of a byte arriving with valid framing and parity.
  task automatic model_push(input logic [7:0] b);
    if (model_q.size() == FIFO_DEPTH) m_ovr = 1'b1;
    else model_q.push_back(b);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; rxd = 1'b1; rd = 1'b0; err_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    model_q.delete();
    m_frame = 1'b0; m_par = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({rx_data, rx_valid, rx_count, frame_err, parity_err, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got data=%h valid=%b count=%0d fe=%b pe=%b ov=%b, want all 0",
               rx_data, rx_valid, rx_count, frame_err, parity_err, overrun);
    end
  endtask

  // 0x55: nothing visible before the mid-stop sample, head present one clock after.
  task automatic test_single_frame();
    send_head(8'h55, 1'b1);
    rxd = 1'b1;
    tick(BAUD_DIV / 2 + 2);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_before_stop: rx_valid=%b want 0", rx_valid);
    end
    tick(1);
    model_push(8'h55);
    n_checks++;
    if ({rx_valid, rx_data, rx_count} !== {1'b1, 8'h55, CW'(1)}) begin
      n_fail++;
      $display("FAIL single_after_stop: valid=%b data=%h count=%0d want 1 55 1", rx_valid, rx_data, rx_count);
    end
    tick(BAUD_DIV / 2);
    pulse_rd();
    n_checks++;
    if ({rx_valid, rx_data, rx_count} !== {1'b0, 8'h00, CW'(0)}) begin
      n_fail++;
      $display("FAIL single_read: valid=%b data=%h count=%0d want 0 00 0", rx_valid, rx_data, rx_count);
    end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(3 * BAUD_DIV);
    n_checks++;
    if ({rx_valid, frame_err, parity_err, overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch: valid=%b fe=%b pe=%b ov=%b want 0 0 0 0", rx_valid, frame_err, parity_err, overrun);
    end
  endtask

  // Fill, overflow, then a push coinciding with a read while full.
  task automatic test_overrun();
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      model_push(8'(i));
    end
    tick(4);
    n_checks++;
    if ({rx_count, overrun} !== {CW'(model_q.size()), m_ovr}) begin
      n_fail++;
      $display("FAIL overrun_full: count=%0d ov=%b want %0d %b", rx_count, overrun, model_q.size(), m_ovr);
    end
    pulse_clr();
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: ov=%b want 0", overrun);
    end
    send_head(8'h99, 1'b1);
    rxd = 1'b1;
    tick(BAUD_DIV / 2 + 2);
    pulse_rd();                  // read lands on the same edge as the stop sample
    model_push(8'h99);
    tick(BAUD_DIV / 2);
    n_checks++;
    if ({rx_count, overrun, rx_data} !== {CW'(FIFO_DEPTH), 1'b0, model_q[0]}) begin
      n_fail++;
      $display("FAIL push_and_read_full: count=%0d ov=%b head=%h want %0d 0 %h",
               rx_count, overrun, rx_data, FIFO_DEPTH, model_q[0]);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      logic [7:0] exp_d;
      exp_d = (model_q.size() != 0) ? model_q[0] : 8'h00;
      n_checks++;
      if ({rx_data, rx_count} !== {exp_d, CW'(model_q.size())}) begin
        n_fail++;
        $display("FAIL drain[%0d]: data=%h count=%0d want %h %0d", i, rx_data, rx_count, exp_d, model_q.size());
      end
      pulse_rd();
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'hA5, 1'b0, 1'b1);
    m_frame = 1'b1;
    tick(2 * BAUD_DIV);
    n_checks++;
    if ({frame_err, rx_valid} !== {m_frame, 1'b0}) begin
      n_fail++; $display("FAIL frame_err_set: fe=%b valid=%b want 1 0", frame_err, rx_valid);
    end
    send_frame(8'h3C, 1'b1, 1'b1);
    model_push(8'h3C);
    tick(2);
    n_checks++;
    if ({rx_data, rx_valid, frame_err} !== {8'h3C, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL frame_recover: data=%h valid=%b fe=%b want 3c 1 1", rx_data, rx_valid, frame_err);
    end
    pulse_clr();
    pulse_rd();
    n_checks++;
    if ({frame_err, rx_valid} !== 2'b00) begin
      n_fail++; $display("FAIL frame_err_clear: fe=%b valid=%b want 0 0", frame_err, rx_valid);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1, 1'b0);
    m_par = 1'b1;
    tick(2);
    n_checks++;
    if ({parity_err, rx_valid} !== {m_par, 1'b0}) begin
      n_fail++; $display("FAIL parity_bad: pe=%b valid=%b want 1 0", parity_err, rx_valid);
    end
    send_frame(8'h01, 1'b1, 1'b1);
    model_push(8'h01);
    tick(2);
    n_checks++;
    if ({rx_data, rx_valid} !== {8'h01, 1'b1}) begin
      n_fail++; $display("FAIL parity_good: data=%h valid=%b want 01 1", rx_data, rx_valid);
    end
    pulse_clr();
    pulse_rd();
  endtask
`endif

  // Random back-to-back frames with random reads in between.
  task automatic test_back_to_back();
    for (int f = 0; f < 14; f++) begin
      logic [7:0] b;
      int nr;
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b1);
      model_push(b);
      nr = $urandom_range(0, 2);
      for (int r = 0; r < nr; r++) begin
        logic [7:0] exp_d;
        exp_d = (model_q.size() != 0) ? model_q[0] : 8'h00;
        n_checks++;
        if ({rx_data, rx_valid, rx_count, overrun} !== {exp_d, model_q.size() != 0, CW'(model_q.size()), m_ovr}) begin
          n_fail++;
          $display("FAIL b2b[%0d.%0d]: data=%h valid=%b count=%0d ov=%b want %h %b %0d %b", f, r,
                   rx_data, rx_valid, rx_count, overrun, exp_d, model_q.size() != 0, model_q.size(), m_ovr);
        end
        pulse_rd();
      end
    end
    tick(2);
    n_checks++;
    if ({rx_count, overrun} !== {CW'(model_q.size()), m_ovr}) begin
      n_fail++;
      $display("FAIL b2b_final: count=%0d ov=%b want %0d %b", rx_count, overrun, model_q.size(), m_ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(8'h96 >> i);
    rxd = 1'b1;
    tick(5);
    apply_reset();
    n_checks++;
    if ({rx_data, rx_valid, rx_count, frame_err, parity_err, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_frame: data=%h valid=%b count=%0d fe=%b pe=%b ov=%b want all 0",
               rx_data, rx_valid, rx_count, frame_err, parity_err, overrun);
    end
    tick(2 * BAUD_DIV);
    send_frame(8'hC3, 1'b1, 1'b1);
    model_push(8'hC3);
    tick(2);
    n_checks++;
    if ({rx_data, rx_count, frame_err} !== {8'hC3, CW'(1), 1'b0}) begin
      n_fail++;
      $display("FAIL after_reset_frame: data=%h count=%0d fe=%b want c3 1 0", rx_data, rx_count, frame_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_overrun();
    test_frame_error();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    // Leave data queued so the mid-frame reset has something to clear.
    send_frame(8'h5A, 1'b1, 1'b1);
    model_push(8'h5A);
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
